// File: rtl/led_pkg.sv
// led_pkg: shared constants and types for the LED PWM fader.
//   DEFAULT_CH    - default number of LED channels
//   DEFAULT_PWM_W - default PWM counter / brightness width
//   max_level()   - full-on brightness code for a given width
//   lvl_t         - brightness level type at the default width
package led_pkg;

  localparam int DEFAULT_CH    = 5;
  localparam int DEFAULT_PWM_W = 8;

  // Largest brightness code for a level of width w (all ones).
  function automatic int max_level(input int w);
    return (1 << w) - 1;
  endfunction

  typedef logic [DEFAULT_PWM_W-1:0] lvl_t;

endpackage

// File: rtl/led_fade_channel.sv
// led_fade_channel: one LED channel of the fader.
//   Holds a saturating brightness level that steps one code toward the
//   channel target on each fade tick, maps it to a PWM duty and drives a
//   registered LED bit.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   tgt       - channel target (1 = fade on, 0 = fade off)
//   fade_tick - one-cycle strobe that allows a level step
//   pwm_cnt   - shared free-running PWM counter
//   led       - registered PWM output
//   at_target - level equals the endpoint selected by tgt
// Build option: LED_PWM_GAMMA_EN selects squared (gamma) duty mapping.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_W = DEFAULT_PWM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt,
  input  logic             fade_tick,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led,
  output logic             at_target
);

  localparam logic [PWM_W-1:0] MAX = PWM_W'(max_level(PWM_W));

  logic [PWM_W-1:0] lvl_reg;
  logic [PWM_W-1:0] lvl_next;
  logic [PWM_W-1:0] duty;
  logic             led_reg;
  logic             led_next;

  // Saturating step toward the target; only moves on a fade tick.
  always_comb begin
    lvl_next = lvl_reg;
    if (fade_tick) begin
      if (tgt && (lvl_reg != MAX)) begin
        lvl_next = lvl_reg + PWM_W'(1);
      end else if (!tgt && (lvl_reg != '0)) begin
        lvl_next = lvl_reg - PWM_W'(1);
      end
    end
  end

`ifdef LED_PWM_GAMMA_EN
  // Squaring the level and keeping the upper half approximates a
  // perceptually linear brightness ramp.
  logic [2*PWM_W-1:0] lvl_sq;
  assign lvl_sq = {{PWM_W{1'b0}}, lvl_reg} * {{PWM_W{1'b0}}, lvl_reg};
  assign duty   = lvl_sq[2*PWM_W-1:PWM_W];
`else
  assign duty = lvl_reg;
`endif

  // Full level forces the LED solidly on; the plain comparator would
  // leave one dark cycle per PWM period.
  assign led_next = (lvl_reg == MAX) || (pwm_cnt < duty);

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_reg <= '0;
      led_reg <= 1'b0;
    end else begin
      lvl_reg <= lvl_next;
      led_reg <= led_next;
    end
  end

  assign led       = led_reg;
  assign at_target = tgt ? (lvl_reg == MAX) : (lvl_reg == '0);

endmodule

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: PWM fading output stage for a CH-bit LED pattern.
//   Each LED ramps its brightness toward the latched on/off target one
//   code per fade tick and is rendered as PWM.
// Ports:
//   clk           - system clock
//   rst           - synchronous active-high reset
//   pattern_in    - target pattern, bit i = 1 fades LED i on
//   pattern_valid - one-cycle strobe that latches pattern_in
//   led           - registered PWM drive to the LED pins
//   busy          - some channel has not yet reached its target
// Build option: LED_PWM_GAMMA_EN enables gamma duty mapping in the channels.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int CH       = DEFAULT_CH,
  parameter int PWM_W    = DEFAULT_PWM_W,
  parameter int FADE_DIV = 12000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] pattern_in,
  input  logic          pattern_valid,
  output logic [CH-1:0] led,
  output logic          busy
);

  localparam int FW = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);

  logic [PWM_W-1:0] pwm_cnt_reg;
  logic [FW-1:0]    fade_cnt_reg;
  logic             fade_tick;
  logic [CH-1:0]    tgt_reg;
  logic [CH-1:0]    at_target;

  assign fade_tick = (fade_cnt_reg == FADE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_reg  <= '0;
      fade_cnt_reg <= '0;
      tgt_reg      <= '0;
    end else begin
      pwm_cnt_reg  <= pwm_cnt_reg + PWM_W'(1);
      fade_cnt_reg <= fade_tick ? '0 : fade_cnt_reg + FW'(1);
      // Channels see the old target this cycle, so a strobe coinciding
      // with a tick only affects the following tick.
      if (pattern_valid) begin
        tgt_reg <= pattern_in;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      led_fade_channel #(
        .PWM_W (PWM_W)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .tgt       (tgt_reg[gi]),
        .fade_tick (fade_tick),
        .pwm_cnt   (pwm_cnt_reg),
        .led       (led[gi]),
        .at_target (at_target[gi])
      );
    end
  endgenerate

  assign busy = ~&at_target;

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: randomized self-checking bench for led_pwm_fader
// (CH=5, PWM_W=4, FADE_DIV=4). A cycle-count based reference model
// predicts led and busy every clock.
module tb_led_pwm_fader;

  localparam int CH       = 5;
  localparam int PWM_W    = 4;
  localparam int FADE_DIV = 4;
  localparam int MAXL     = (1 << PWM_W) - 1;
  localparam int PERIOD   = 1 << PWM_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] pattern_in = '0;
  logic          pattern_valid = 1'b0;
  logic [CH-1:0] led;
  logic          busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: cycles since reset, per-channel level, target.
  int      m_n;
  int      m_lvl [CH];
  int      m_tgt [CH];
  int      exp_led;
  int      exp_busy;

  always #5 clk = ~clk;

  led_pwm_fader #(
    .CH       (CH),
    .PWM_W    (PWM_W),
    .FADE_DIV (FADE_DIV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pattern_in    (pattern_in),
    .pattern_valid (pattern_valid),
    .led           (led),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d since reset)", tag, obs, exp_v, m_n);
    end
  endtask

  function automatic int duty_of(input int l);
`ifdef LED_PWM_GAMMA_EN
    return (l * l) >> PWM_W;
`else
    return l;
`endif
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic r, input logic pv, input logic [CH-1:0] p);
    int pwm;
    bit tick;
    if (r) begin
      m_n = 0;
      exp_led = 0;
      for (int i = 0; i < CH; i++) begin
        m_lvl[i] = 0;
        m_tgt[i] = 0;
      end
    end else begin
      pwm  = m_n % PERIOD;
      tick = (m_n % FADE_DIV) == (FADE_DIV - 1);
      exp_led = 0;
      for (int i = 0; i < CH; i++) begin
        if (m_lvl[i] == MAXL || pwm < duty_of(m_lvl[i])) exp_led |= (1 << i);
        if (tick) begin
          if (m_tgt[i] == 1 && m_lvl[i] < MAXL) m_lvl[i]++;
          else if (m_tgt[i] == 0 && m_lvl[i] > 0) m_lvl[i]--;
        end
        if (pv) m_tgt[i] = p[i];
      end
      m_n++;
    end
    exp_busy = 0;
    for (int i = 0; i < CH; i++) begin
      if (m_lvl[i] != (m_tgt[i] ? MAXL : 0)) exp_busy = 1;
    end
  endtask

  // One clock: apply inputs, let the edge happen, then compare on the falling edge.
  task automatic cyc(input logic r, input logic pv, input logic [CH-1:0] p);
    rst = r;
    pattern_valid = pv;
    pattern_in = p;
    @(posedge clk);
    model_step(r, pv, p);
    @(negedge clk);
    check("led", 32'(led), 32'(exp_led));
    check("busy", 32'(busy), 32'(exp_busy));
    rst = 1'b0;
    pattern_valid = 1'b0;
  endtask

  task automatic load(input logic [CH-1:0] p, input int hold);
    $display("[TB] load pattern %05b, hold %0d clk", p, hold);
    cyc(1'b0, 1'b1, p);
    repeat (hold) cyc(1'b0, 1'b0, $urandom());
  endtask

  initial begin
    @(negedge clk);
    // Reset for 3 cycles, then idle: led and busy stay 0.
    repeat (3) cyc(1'b1, 1'b0, '0);
    $display("[TB] reset released");
    repeat (20) cyc(1'b0, 1'b0, '0);

    // Ramp channel 0 fully on, then wait for saturation.
    load(5'b00001, 70);

    // Partial ramp then back off, to check the floor.
    cyc(1'b1, 1'b0, '0);
    load(5'b00001, 20);
    load(5'b00000, 30);

    // Strobe exactly on a fade tick: the tick must still use the old target.
    load(5'b00001, 8);
    while ((m_n % FADE_DIV) != (FADE_DIV - 1)) cyc(1'b0, 1'b0, '0);
    load(5'b00000, 12);

    // Reset mid-fade, then resume.
    load(5'b00100, 28);
    $display("[TB] reset pulse mid-fade");
    cyc(1'b1, 1'b0, '0);
    load(5'b00100, 10);

    // Random patterns with random hold lengths and occasional resets.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        $display("[TB] random reset pulse");
        cyc(1'b1, 1'b0, '0);
      end
      load(CH'($urandom()), $urandom_range(0, 90));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream output stage for the 5-bit LED counter on the iCE40 icestick. It takes the counter's LED pattern as a per-channel on/off target and drives the physical LED pins. Each LED fades toward its target with a saturating brightness ramp, rendered as PWM. This makes counter transitions visible as smooth fades instead of hard toggles.

## Interface
Parameters:
- CH, 5, number of LED channels
- PWM_W, 8, PWM counter and brightness level width in bits
- FADE_DIV, 12000, clocks per fade step; must be ≥ 2 (1 ms at 12 MHz)

Ports:
- clk  in  1  single system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- pattern_in  in  CH  target pattern; bit i = 1 means LED i fades on
- pattern_valid  in  1  single-cycle strobe that latches pattern_in
- led  out  CH  registered PWM drive to the LED pins
- busy  out  1  high while any channel level differs from its target

## Operation
- pwm_cnt (PWM_W bits) is free-running, +1 every clk, and wraps from 2^PWM_W−1 to 0. Reset value 0.
- fade_cnt counts 0..FADE_DIV−1. While fade_cnt == FADE_DIV−1, fade_tick is high for that one cycle, then fade_cnt wraps to 0. Reset value 0.
- tgt (CH bits) loads pattern_in in any cycle with pattern_valid = 1; otherwise it holds. Reset value 0.
- lvl[i] (PWM_W bits, per channel) changes only on fade_tick:
  - tgt[i] = 1 and lvl[i] < MAX (MAX = 2^PWM_W−1): lvl[i] + 1
  - tgt[i] = 0 and lvl[i] > 0: lvl[i] − 1
  - otherwise hold; saturating, so there is never wrap-around
  - Reset value 0.
- duty[i] = lvl[i] (see Configuration).
- led[i] next value:
  - 1 if lvl[i] == MAX (fully on, no 1/2^PWM_W gap)
  - otherwise (pwm_cnt < duty[i])
  - lvl = 0 gives a constant 0.
- busy = OR over i of (lvl[i] != (tgt[i] ? MAX : 0)). It is combinational from registers. Reset value 0.
- Reset mid-fade: the next cycle shows all levels, counters and tgt at 0, with led = 0 and busy = 0.

## Timing
- pattern_valid at cycle t gives tgt updated at t+1 and busy high at t+1 if the new target differs.
- fade_tick together with pattern_valid in the same cycle: the step uses the old tgt. The new target first acts on the next tick.
- A full ramp from 0 to MAX takes MAX ticks, which is MAX·FADE_DIV clocks (255·12000 at defaults).
- led is registered, so it follows pwm_cnt and lvl with a latency of 1 clk.
- The PWM period is 2^PWM_W clocks. led[i] is high for exactly duty[i] cycles per period, except when lvl = MAX.

## Configuration
- LED_PWM_GAMMA_EN defined: duty[i] = (lvl[i]·lvl[i]) >> PWM_W, giving a perceptually linear fade. The lvl == MAX override still applies.
- LED_PWM_GAMMA_EN undefined: duty[i] = lvl[i] (linear). No multiplier is inferred.

## Structure
- Package led_pkg holds:
  - default PWM_W and CH
  - the MAX level constant function
  - the lvl_t typedef (logic [PWM_W−1:0])
- Sub-module led_fade_channel is instantiated CH times. Each instance contains:
  - lvl register and saturating step logic
  - gamma/duty mapping
  - PWM comparator and registered led bit
  - at_target output, which the top ORs into busy
- The top-level led_pwm_fader owns pwm_cnt, fade_cnt, tgt and the busy reduction.

## Test plan
Run with PWM_W=4 and FADE_DIV=4 unless noted.
1. rst high for 3 cycles, then low with pattern_valid = 0: led = 0 and busy = 0 throughout; pwm_cnt starts from 0.
2. pattern_in = 5'b00001 with a 1-cycle pattern_valid:
   - busy goes to 1 the next cycle
   - lvl[0] reaches 15 after 15 ticks (60 clk)
   - led[0] is then constant 1 and busy = 0
   - led[4:1] stay 0
3. Duty check with lvl[0] held at 8: without the macro, led[0] is high 8 of every 16 clk. With LED_PWM_GAMMA_EN, it is high 4 of every 16 clk.
4. After 5 ticks toward on, pattern_in = 0: lvl[0] steps 5→4→…→0 over 5 ticks with no underflow. busy drops the cycle lvl reaches 0.
5. pattern_valid asserted in the same cycle as fade_tick, changing the target from 1 to 0: that tick still increments lvl, and the following tick decrements it.
6. rst pulsed for 1 cycle mid-fade with lvl[2] = 7: the next cycle shows led = 0, lvl = 0, tgt = 0 and busy = 0, and the block resumes cleanly on the next pattern_valid.
